// File: rtl/led_fade_pkg.sv
// Shared constants and helpers for the LED fade driver.
package led_fade_pkg;

  localparam int unsigned LED_PWM_BITS_DEF = 8;
  localparam int unsigned LED_STEP_DIV_DEF = 50000;

  // Smallest w with 2**w >= value; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned max_level(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating brightness ramp, bypass forcing and PWM output flop.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS = LED_PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                step_tick,
  input  logic                req,
  input  logic [PWM_BITS-1:0] target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led_out
);

  logic [PWM_BITS-1:0] level_q, level_d;

  // Target is only ever 0 or the maximum, so stepping toward it cannot wrap.
  always_comb begin
    level_d = level_q;
    if (!enable) begin
      level_d = target;
    end else if (step_tick) begin
      if (level_q < target) begin
        level_d = level_q + PWM_BITS'(1);
      end else if (level_q > target) begin
        level_d = level_q - PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      led_out <= 1'b0;
    end else begin
      level_q <= level_d;
      led_out <= enable ? (pwm_cnt < level_q) : req;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/led_fade_driver.sv
// PWM fade stage between the LED PIO out_port and the LEDR pins, with a bypass mode.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PWM_BITS = LED_PWM_BITS_DEF,
  parameter int unsigned STEP_DIV = LED_STEP_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_LEDS-1:0] led_req,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int unsigned PrescW = (clog2(STEP_DIV) < 1) ? 1 : clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] MaxLevel = PWM_BITS'(max_level(PWM_BITS));
  localparam logic [PWM_BITS-1:0] PwmLast = MaxLevel - PWM_BITS'(1);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(STEP_DIV - 1);

  logic [NUM_LEDS-1:0]               req_q;
  logic [PrescW-1:0]                 presc_q;
  logic [PWM_BITS-1:0]               pwm_cnt_q;
  logic                              step_tick;
  logic                              any_diff;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] target;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] level;

  assign step_tick = enable && (presc_q == PrescLast);

  always_comb begin
    any_diff = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      target[i] = req_q[i] ? MaxLevel : '0;
      any_diff  = any_diff | (level[i] != target[i]);
    end
  end

  // pwm_cnt stops at MaxLevel-1 so a full-scale level yields a constant high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      busy      <= 1'b0;
    end else begin
      req_q     <= led_req;
      busy      <= any_diff;
      pwm_cnt_q <= (pwm_cnt_q == PwmLast) ? '0 : pwm_cnt_q + PWM_BITS'(1);
      if (!enable || presc_q == PrescLast) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PrescW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .step_tick (step_tick),
      .req       (req_q[g]),
      .target    (target[g]),
      .pwm_cnt   (pwm_cnt_q),
      .level     (level[g]),
      .led_out   (led_out[g])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver at PWM_BITS=4 with a fast and a slow step divider.
module tb_led_fade_driver;

  localparam int unsigned NumLeds = 4;
  localparam int unsigned PwmBits = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic [NumLeds-1:0] led_req;
  logic [NumLeds-1:0] led_out;
  logic               busy;
  logic [NumLeds-1:0] slow_req;
  logic [NumLeds-1:0] slow_out;
  logic               slow_busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_LEDS (NumLeds),
    .PWM_BITS (PwmBits),
    .STEP_DIV (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .led_req (led_req),
    .led_out (led_out),
    .busy    (busy)
  );

  led_fade_driver #(
    .NUM_LEDS (NumLeds),
    .PWM_BITS (PwmBits),
    .STEP_DIV (64)
  ) dut_slow (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (1'b1),
    .led_req (slow_req),
    .led_out (slow_out),
    .busy    (slow_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns 1ns after the n-th rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1ns after release; the next rising edge is edge 1.
  task automatic reset_dut();
    @(posedge clk);
    #3 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int hi;
    int other;
    reset_n  = 1'b0;
    enable   = 1'b1;
    led_req  = '0;
    slow_req = '0;

    // Ramp up channel 0
    reset_dut();
    step(1);
    led_req = 4'b0001;
    step(1); check("ramp_busy_e2", 32'(busy), 32'd0);
    step(1); check("ramp_busy_e3", 32'(busy), 32'd1);
    step(1); check("ramp_lvl_e4", 32'(dut.level[0]), 32'd1);
    step(3); check("ramp_lvl_e7", 32'(dut.level[0]), 32'd1);
    step(1); check("ramp_lvl_e8", 32'(dut.level[0]), 32'd2);
    step(51); check("ramp_lvl_e59", 32'(dut.level[0]), 32'd14);
    step(1); check("ramp_lvl_e60", 32'(dut.level[0]), 32'd15);
    check("ramp_busy_e60", 32'(busy), 32'd1);
    step(1); check("ramp_busy_e61", 32'(busy), 32'd0);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      hi += int'(led_out[0]);
    end
    check("ramp_full_on", 32'(hi), 32'd30);
    check("ramp_sat_max", 32'(dut.level[0]), 32'd15);

    // Asynchronous reset mid-run, then release into bypass
    led_req = 4'hF;
    step(5);
    #2 reset_n = 1'b0;
    #1;
    check("rst_led_out", 32'(led_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1); check("byp_out_e1", 32'(led_out), 32'h0);
    step(1); check("byp_out_e2", 32'(led_out), 32'hF);
    step(1); check("byp_busy_e3", 32'(busy), 32'd0);
    check("byp_levels", 32'(dut.level), 32'hFFFF);

    // Reversal on channel 2
    enable  = 1'b1;
    led_req = 4'b0100;
    reset_dut();
    step(28); check("rev_lvl7", 32'(dut.level[2]), 32'd7);
    led_req = 4'b0000;
    step(4);  check("rev_lvl6", 32'(dut.level[2]), 32'd6);
    step(24); check("rev_lvl0", 32'(dut.level[2]), 32'd0);
    step(4);  check("rev_sat_min", 32'(dut.level[2]), 32'd0);
    led_req = 4'b0100;
    step(4);  check("rev_resume", 32'(dut.level[2]), 32'd1);

    // Bypass toggle mid-ramp on channel 0
    led_req = 4'b0001;
    reset_dut();
    step(36); check("tog_lvl9", 32'(dut.level[0]), 32'd9);
    enable = 1'b0;
    step(1); check("tog_forced", 32'(dut.level[0]), 32'd15);
    check("tog_out", 32'(led_out), 32'h1);
    step(1); check("tog_busy", 32'(busy), 32'd0);
    enable  = 1'b1;
    led_req = 4'b0000;
    step(3); check("tog_hold15", 32'(dut.level[0]), 32'd15);
    step(1); check("tog_down14", 32'(dut.level[0]), 32'd14);
    step(4); check("tog_down13", 32'(dut.level[0]), 32'd13);

    // Request change landing on a step tick
    led_req = 4'b0011;
    reset_dut();
    step(20); check("sim_pre", 32'(dut.level), 32'h0055);
    step(3);
    led_req = 4'b1100;
    step(1); check("sim_tick_old_req", 32'(dut.level), 32'h0066);
    step(4); check("sim_tick_new_req", 32'(dut.level), 32'h1155);

    // Duty at a held level of 5 on the slow instance, channel 1
    slow_req = 4'b0010;
    led_req  = 4'b0000;
    reset_dut();
    step(329);
    hi    = 0;
    other = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      hi    += int'(slow_out[1]);
      other |= int'(slow_out[0] | slow_out[2] | slow_out[3]);
    end
    check("duty_5of15", 32'(hi), 32'd5);
    check("duty_idle_off", 32'(other), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
